// File: rtl/dbus_responder_pkg.sv
// Shared types for the data-bus responder: bus request/response structs,
// the default base address and the responder state encoding.
package dbus_responder_pkg;

    localparam logic [63:0] DBUS_BASE_ADDR = 64'h8000_0000;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dbus_state_t;

endpackage

// File: rtl/dbus_responder_if.sv
// Data-bus channel between the memory stage (master) and a responder (slave).
interface dbus_responder_if;
    import dbus_responder_pkg::*;

    dbus_req_t  dreq;
    dbus_resp_t dresp;

    modport master (output dreq, input dresp);
    modport slave  (input dreq, output dresp);
endinterface

// File: rtl/dbus_responder_ram.sv
// Word-addressed 64-bit backing store: byte-strobed synchronous write,
// asynchronous read.
module dbus_ram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [7:0]       strobe,
    input  logic [IDX_W-1:0] widx,
    input  logic [63:0]      wdata,
    input  logic [IDX_W-1:0] ridx,
    output logic [63:0]      rdata
);

    logic [63:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 8; i++) begin
                if (strobe[i]) begin
                    mem[widx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/dbus_responder.sv
// Simulation memory slave for the pipeline data bus: one outstanding
// transaction, fixed response latency, sticky out-of-range error flag.
module dbus_responder
    import dbus_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [63:0] BASE_ADDR   = DBUS_BASE_ADDR
) (
    input  logic              clk,
    input  logic              reset,
    dbus_responder_if.slave   dbus,
    output logic              err
);

    localparam int         IDX_W  = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("dbus_responder: LATENCY must be within 1..15");
    end
    if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
        $error("dbus_responder: DEPTH_WORDS must be a power of two >= 2");
    end

    dbus_state_t      state;
    logic [3:0]       counter;
    logic [IDX_W-1:0] idx_q;
    logic [7:0]       strobe_q;
    logic [63:0]      wdata_q;
    logic [63:0]      rdata_q;
    logic             is_write;
    logic             oor_q;
    logic             data_ok_q;
    logic [63:0]      data_q;

    logic [63:0]      offset;
    logic [IDX_W-1:0] req_idx;
    logic             in_range;
    logic [63:0]      ram_rdata;
    logic             ram_we;
    logic             unused;

    // Bits above the index field must be zero, otherwise the word lies past the RAM.
    assign offset   = dbus.dreq.addr - BASE_ADDR;
    assign req_idx  = offset[IDX_W+2:3];
    assign in_range = (dbus.dreq.addr >= BASE_ADDR) && (offset[63:IDX_W+3] == '0);
    assign unused   = ^{offset[2:0], dbus.dreq.size};

    // The commit happens on the edge that ends RESP, and a reset on that edge cancels it.
    assign ram_we = reset && (state == RESP) && is_write && !oor_q;

    dbus_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_ram (
        .clk    (clk),
        .we     (ram_we),
        .strobe (strobe_q),
        .widx   (idx_q),
        .wdata  (wdata_q),
        .ridx   (req_idx),
        .rdata  (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            counter   <= '0;
            err       <= 1'b0;
            data_ok_q <= 1'b0;
            data_q    <= '0;
        end else begin
            data_ok_q <= 1'b0;
            data_q    <= '0;
            case (state)
                IDLE: begin
                    if (dbus.dreq.valid) begin
                        idx_q    <= req_idx;
                        strobe_q <= dbus.dreq.strobe;
                        wdata_q  <= dbus.dreq.data;
                        is_write <= |dbus.dreq.strobe;
                        oor_q    <= !in_range;
                        rdata_q  <= in_range ? ram_rdata : '0;
                        counter  <= LAT_M1;
                        if (LATENCY > 1) begin
                            state <= WAIT;
                        end else begin
                            state     <= RESP;
                            data_ok_q <= 1'b1;
                            data_q    <= in_range ? ram_rdata : '0;
                            if (!in_range) begin
                                err <= 1'b1;
                            end
                        end
                    end
                end
                WAIT: begin
                    if (counter == 4'd1) begin
                        counter   <= '0;
                        state     <= RESP;
                        data_ok_q <= 1'b1;
                        data_q    <= rdata_q;
                        if (oor_q) begin
                            err <= 1'b1;
                        end
                    end else begin
                        counter <= counter - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign dbus.dresp = '{addr_ok: (state == IDLE) && dbus.dreq.valid,
                          data_ok: data_ok_q,
                          data:    data_q};

endmodule

// File: tb/tb_dbus_responder.sv
// Scoreboard bench for dbus_responder: three instances (LATENCY 2, 4, 1)
// checked against a word-array reference model.
module tb_dbus_responder;
    import dbus_responder_pkg::*;

    localparam int          DW   = 16;
    localparam int          NL   = 3;
    localparam logic [63:0] BASE = 64'h8000_0000;

    typedef struct {
        int          dut;
        logic [63:0] data;
        int          due;
        bit          chk;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dbus_req_t  req  [NL];
    dbus_resp_t rsp  [NL];
    logic       errs [NL];

    dbus_responder_if bus0 ();
    dbus_responder_if bus1 ();
    dbus_responder_if bus2 ();

    assign bus0.dreq = req[0];
    assign bus1.dreq = req[1];
    assign bus2.dreq = req[2];
    assign rsp[0]    = bus0.dresp;
    assign rsp[1]    = bus1.dresp;
    assign rsp[2]    = bus2.dresp;

    dbus_responder #(.DEPTH_WORDS(DW), .LATENCY(2), .BASE_ADDR(BASE)) dut0 (
        .clk(clk), .reset(reset), .dbus(bus0), .err(errs[0]));
    dbus_responder #(.DEPTH_WORDS(DW), .LATENCY(4), .BASE_ADDR(BASE)) dut1 (
        .clk(clk), .reset(reset), .dbus(bus1), .err(errs[1]));
    dbus_responder #(.DEPTH_WORDS(DW), .LATENCY(1), .BASE_ADDR(BASE)) dut2 (
        .clk(clk), .reset(reset), .dbus(bus2), .err(errs[2]));

    // Reference model: one word array per instance, writes applied at issue time.
    logic [63:0] mem_m [NL][DW];
    bit          known [NL][DW];
    bit          errm  [NL];
    exp_t        sbq   [$];
    logic [63:0] last_data [NL];
    exp_t        mon_e;
    int          checks = 0;
    int          passes = 0;

    function automatic int lat_of(input int k);
        case (k)
            0:       return 2;
            1:       return 4;
            default: return 1;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("[TB] FAIL %s: got %h, required %h", name, act, expv);
    endtask

    function automatic void model_issue(input int k, input logic [63:0] a, input logic [7:0] s,
                                        input logic [63:0] d, input int acc);
        logic [63:0] off;
        bit          inr;
        int          idx;
        exp_t        e;
        off   = a - BASE;
        inr   = (a >= BASE) && (off / 8 < 64'(DW));
        e.dut = k;
        e.due = acc + lat_of(k) - 1;
        e.data = '0;
        e.chk  = 1'b1;
        if (inr) begin
            idx    = int'(off / 8);
            e.data = mem_m[k][idx];
            e.chk  = known[k][idx];
            for (int b = 0; b < 8; b++) begin
                if (s[b]) mem_m[k][idx][8*b +: 8] = d[8*b +: 8];
            end
            if (s == 8'hFF) known[k][idx] = 1'b1;
        end else begin
            errm[k] = 1'b1;
        end
        sbq.push_back(e);
    endfunction

    task automatic applyStimulus(input int k, input logic [63:0] a, input logic [7:0] s,
                                 input logic [63:0] d);
        int n;
        n = 0;
        @(negedge clk);
        req[k].valid  = 1'b1;
        req[k].addr   = a;
        req[k].size   = 3'd3;
        req[k].strobe = s;
        req[k].data   = d;
        #1;
        while (!rsp[k].addr_ok && n < 64) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (rsp[k].addr_ok) begin
            passes++;
            model_issue(k, a, s, d, cyc + 1);
        end else begin
            $display("[TB] FAIL accept_timeout dut%0d: addr_ok=0 after %0d cycles, required 1", k, n);
        end
        @(negedge clk);
        req[k].valid = 1'b0;
        req[k].addr  = {$urandom, $urandom};
        req[k].data  = {$urandom, $urandom};
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge clk);
            #2;
            n++;
        end
        checks++;
        if (sbq.size() == 0) passes++;
        else begin
            $display("[TB] FAIL drain: %0d responses outstanding, required 0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic rand_txn(input int k);
        logic [63:0] a;
        logic [7:0]  s;
        int          r;
        r = int'($urandom_range(0, 9));
        if (r == 0)      a = BASE - 64'(8 * $urandom_range(1, 4));
        else if (r == 1) a = BASE + 64'(8 * (DW + $urandom_range(0, 3)));
        else             a = BASE + 64'(8 * $urandom_range(0, DW - 1));
        a[2:0] = 3'($urandom_range(0, 7));
        s = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
        applyStimulus(k, a, s, {$urandom, $urandom});
    endtask

    task automatic checkOutput(input int k, input string name);
        check(name, 64'(errs[k]), 64'(errm[k]));
    endtask

    // Monitor: every response pops the oldest expectation; outside RESP data must be zero.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            for (int k = 0; k < NL; k++) begin
                if (rsp[k].data_ok) begin
                    last_data[k] = rsp[k].data;
                    if (sbq.size() == 0) begin
                        checks++;
                        $display("[TB] FAIL unexpected_data_ok dut%0d: data_ok=1, required 0", k);
                    end else begin
                        mon_e = sbq.pop_front();
                        check("resp_dut", 64'(k), 64'(mon_e.dut));
                        check("resp_cycle", 64'(cyc), 64'(mon_e.due));
                        if (mon_e.chk) check("resp_data", rsp[k].data, mon_e.data);
                    end
                end else begin
                    check("idle_data", rsp[k].data, 64'd0);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int k = 0; k < NL; k++) begin
            req[k]  = '0;
            errm[k] = 1'b0;
            for (int i = 0; i < DW; i++) known[k][i] = 1'b0;
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < NL; k++) begin
            check("rst_data_ok", 64'(rsp[k].data_ok), 64'd0);
            check("rst_data", rsp[k].data, 64'd0);
            check("rst_err", 64'(errs[k]), 64'd0);
        end
        reset = 1'b1;

        for (int k = 0; k < NL; k++) begin
            for (int i = 0; i < DW; i++) applyStimulus(k, BASE + 64'(8 * i), 8'hFF, {$urandom, $urandom});
            drain();
        end

        // Write/read and byte-strobe merge at LATENCY 2.
        applyStimulus(0, 64'h8000_0010, 8'hFF, 64'h1122_3344_5566_7788);
        applyStimulus(0, 64'h8000_0010, 8'h00, 64'd0);
        drain();
        check("wr_rd_const", last_data[0], 64'h1122_3344_5566_7788);
        applyStimulus(0, 64'h8000_0010, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB);
        drain();
        check("merge_prewrite", last_data[0], 64'h1122_3344_5566_7788);
        applyStimulus(0, 64'h8000_0010, 8'h00, 64'd0);
        drain();
        check("merge_const", last_data[0], 64'h1122_3344_BBBB_BBBB);

        // Request changes while waiting must not affect the response.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            req[k] = '{valid: 1'b1, addr: 64'h8000_0010, size: 3'd3, strobe: 8'h00, data: 64'd0};
            #1;
            check("wait_accept", 64'(rsp[k].addr_ok), 64'd1);
            model_issue(k, 64'h8000_0010, 8'h00, 64'd0, cyc + 1);
            for (int j = 0; j < lat_of(k); j++) begin
                @(negedge clk);
                req[k].addr   = BASE + 64'(8 * $urandom_range(0, DW - 1));
                req[k].strobe = 8'($urandom);
                if (j == lat_of(k) - 1) req[k].valid = 1'b0;
                #1;
                check("wait_addr_ok", 64'(rsp[k].addr_ok), 64'd0);
            end
            drain();
        end

        // Out-of-range accesses complete with zero data and set the sticky flag.
        applyStimulus(0, 64'h7FFF_FFF8, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF);
        drain();
        checkOutput(0, "err_after_oor");
        applyStimulus(0, BASE + 64'(8 * DW), 8'h00, 64'd0);
        applyStimulus(0, BASE, 8'h00, 64'd0);
        drain();
        checkOutput(0, "err_sticky");

        for (int k = 0; k < NL; k++) begin
            for (int t = 0; t < 30; t++) rand_txn(k);
            drain();
            checkOutput(k, "err_random");
        end

        // Reset during WAIT aborts the write and clears err.
        @(negedge clk);
        req[1] = '{valid: 1'b1, addr: BASE + 64'h30, size: 3'd3, strobe: 8'hFF, data: 64'h0BAD_F00D_0BAD_F00D};
        #1;
        check("abort_accept", 64'(rsp[1].addr_ok), 64'd1);
        @(negedge clk);
        #1;
        check("abort_wait_addr_ok", 64'(rsp[1].addr_ok), 64'd0);
        req[1].valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < NL; k++) errm[k] = 1'b0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            #1;
            check("abort_data_ok", 64'(rsp[1].data_ok), 64'd0);
        end
        for (int k = 0; k < NL; k++) checkOutput(k, "err_cleared");
        @(negedge clk);
        req[1] = '{valid: 1'b1, addr: BASE + 64'h30, size: 3'd3, strobe: 8'h00, data: 64'd0};
        #1;
        check("post_rst_addr_ok", 64'(rsp[1].addr_ok), 64'd1);
        model_issue(1, BASE + 64'h30, 8'h00, 64'd0, cyc + 1);
        @(negedge clk);
        req[1].valid = 1'b0;
        drain();

        // LATENCY 1 with valid held high: IDLE and RESP alternate.
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            req[2].valid  = 1'b1;
            req[2].strobe = 8'h00;
            if (j % 2 == 0) req[2].addr = BASE + 64'(8 * ((j / 2) % DW));
            #1;
            check("b2b_addr_ok", 64'(rsp[2].addr_ok), 64'(j % 2 == 0));
            check("b2b_data_ok", 64'(rsp[2].data_ok), 64'(j % 2 == 1));
            if (rsp[2].addr_ok) model_issue(2, req[2].addr, 8'h00, 64'd0, cyc + 1);
            if (j == 11) req[2].valid = 1'b0;
        end
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/dbus_responder.md
Name: dbus_responder

Overview:
- Slave end of the data bus that the pipeline memory stage drives: accepts `dbus_req_t`, returns `dbus_resp_t`.
- Backed by a word-addressed 64-bit RAM with byte strobes and a programmable fixed response latency.
- Used as the simulation memory model for the pipeline, and as the template for later cache or bus-bridge responders.
- Services one outstanding transaction at a time.

Parameters:
- DEPTH_WORDS, 1024, number of 64-bit words in backing RAM (power of two).
- LATENCY, 2, cycles from request acceptance to data_ok (legal range 1..15).
- BASE_ADDR, 64'h8000_0000, byte address mapped to word 0.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- dreq  in  dbus_req_t  fields: valid, addr[63:0], size, strobe[7:0], data[63:0].
- dresp  out  dbus_resp_t  fields: addr_ok, data_ok, data[63:0].
- err  out  1  sticky out-of-range access flag.

Behaviour:
- Reset (reset==0 at an edge):
  - state=IDLE, counter=0, err=0, dresp.data_ok=0, dresp.data=0.
  - RAM contents untouched.
  - An in-flight transaction is aborted and its write is never committed.
- States:
  - IDLE: dresp.addr_ok = dreq.valid (combinational, IDLE only). On an edge with dreq.valid=1:
    - latch addr, strobe, data, and is_write (strobe!=0);
    - counter=LATENCY-1;
    - next state WAIT if LATENCY>1, else RESP.
  - WAIT: counter decrements each cycle; at 0 go to RESP. dreq is ignored because the latched copy is authoritative; changes to dreq during WAIT have no effect.
  - RESP: dresp.data_ok=1 for exactly this one cycle, with dresp.data valid. Next state IDLE unconditionally.
- Latency:
  - Request accepted at edge N gives data_ok high during cycle N+LATENCY.
  - A new request is accepted no earlier than the cycle after data_ok, so the minimum issue interval is LATENCY+1 cycles.
- Indexing: index = (addr - BASE_ADDR) >> 3. addr[2:0] and size are ignored for indexing. The bus carries aligned 8-byte words and the core performs byte-lane selection and extension.
- Read (strobe==0): dresp.data = RAM[index] as sampled at acceptance.
- Write (strobe!=0):
  - bytes i with strobe[i]=1 are replaced by data[8i+7:8i] at the edge ending the RESP cycle;
  - dresp.data = pre-write word (read-before-write);
  - unstrobed bytes are preserved.
- Out of range (addr < BASE_ADDR or index >= DEPTH_WORDS):
  - handshake completes normally;
  - dresp.data=0 and the write is dropped;
  - err set to 1 at the RESP edge and held until reset.
- dresp.data is 0 in every cycle except RESP.
- Simultaneous events:
  - reset overrides everything;
  - dreq.valid arriving in RESP is not accepted; it is accepted the next cycle in IDLE if still valid.
- Counter width: 4 bits. LATENCY outside 1..15 is a parameter error, caught by an elaboration-time `$error`.

Decomposition:
- Package `pipes`: add `DBUS_BASE_ADDR` and the responder state enum (`IDLE`, `WAIT`, `RESP`). `dbus_req_t`/`dbus_resp_t` are reused from `common`; no new bus types.
- One sub-module, `dbus_ram`:
  - synchronous-write, asynchronous-read RAM with DEPTH_WORDS×64;
  - ports: clk, we, strobe[7:0], widx, wdata, ridx, rdata.
- The FSM, counter, range check and error flag stay in `dbus_responder`.

Test Plan:
- Write then read (LATENCY=2): write addr 0x8000_0010, strobe 0xFF, data 0x1122334455667788, accepted edge N, data_ok in cycle N+2. Then read the same addr → data_ok two cycles later with data 0x1122334455667788.
- Byte strobe merge: after the above, write strobe 0x0F, data 0xAAAAAAAA_BBBBBBBB → that write returns 0x1122334455667788. A subsequent read returns 0x11223344_BBBBBBBB.
- Request change during WAIT: accept a read of 0x8000_0010, then switch dreq.addr to 0x8000_0020 in WAIT → response data is still the word from 0x8000_0010. addr_ok=0 throughout WAIT.
- Out of range: write to 0x7FFF_FFF8, then read 0x8000_0000+8*DEPTH_WORDS → both complete with data 0, err=1 after the first. RAM word 0 is unchanged. err clears only on reset=0.
- Reset mid-operation: accept a write at LATENCY=4, drive reset=0 for one edge in WAIT → state IDLE, data_ok never pulses. A read of the same addr returns the old contents.
- LATENCY=1 back-to-back with valid held high: data_ok every second cycle, one cycle high then one low. addr_ok is high only in IDLE cycles.
